pin_entry_controller: RTL and testbench
=======================================

PIN_ENTRY_CONTROLLER -- requirements
Module: pin_entry_controller

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 3, meaning wrong-PIN attempts allowed per card before lockout.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning idle cycles in GET_PIN before abandon.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 card_insert  input  1  one-cycle pulse; latches acc_num_in.
REQ-006 acc_num_in  input  4  account number from card.
REQ-007 digit_valid  input  1  keypad digit strobe.
REQ-008 digit  input  4  keypad digit; only 0-9 are legal.
REQ-009 cancel  input  1  user abort.
REQ-010 auth_found  input  1  account-found status from authenticator, combinational from acc_num_out.
REQ-011 auth_pin_ok  input  1  PIN-match status from downstream, combinational from pin_out.
REQ-012 acc_num_out  output  4  latched account number to authenticator.
REQ-013 pin_out  output  16  binary PIN value (decimal digits accumulated).
REQ-014 auth_req  output  1  one-cycle check strobe.
REQ-015 authenticated  output  1  level; session open.
REQ-016 locked  output  1  level; card locked out.
REQ-017 fail  output  1  one-cycle pulse on a failed check.
REQ-018 tries_left  output  2  remaining attempts.
REQ-019 timeout  output  1  one-cycle pulse on inactivity abandon.

Function
REQ-020 SHALL implement states IDLE, GET_PIN, CHECK, AUTH_OK, LOCKED.
REQ-021 IDLE + card_insert: latch acc_num_in, clear pin_out and digit count, set tries_left=MAX_TRIES, go GET_PIN next cycle.
REQ-022 card_insert outside IDLE SHALL be ignored.
REQ-023 GET_PIN + digit_valid with digit<=9: pin_out <= pin_out*10 + digit (16-bit, no overflow for 4 digits, max 9999); digit count increments.
REQ-024 digit>9 with digit_valid SHALL be ignored: no count, no pin change.
REQ-025 On the cycle the 4th legal digit is accepted, the state SHALL become CHECK on the next edge; further digits are ignored.
REQ-026 In CHECK, auth_req SHALL be 1 for exactly that cycle; auth_found/auth_pin_ok are sampled at its end. Latency: one cycle after 4th digit.
REQ-027 CHECK, found & pin_ok: go AUTH_OK, authenticated=1 from next cycle.
REQ-028 CHECK, !found: fail pulse, go IDLE; tries_left unchanged.
REQ-029 CHECK, found & !pin_ok: fail pulse, tries_left decrements; if new value is 0, go LOCKED, else GET_PIN with pin_out and count cleared.
REQ-030 AUTH_OK SHALL hold until cancel, then go IDLE with authenticated=0 next cycle.
REQ-031 LOCKED: locked=1; SHALL ignore all inputs; exit only via rst.
REQ-032 cancel in GET_PIN or CHECK SHALL go IDLE, overriding a same-cycle digit_valid or check result; no fail pulse.
REQ-033 tries_left SHALL never wrap below 0.
REQ-034 acc_num_out and pin_out SHALL remain stable throughout CHECK.

Reset
REQ-035 rst SHALL force state IDLE, acc_num_out=0, pin_out=0, digit count 0, auth_req=0, authenticated=0, locked=0, fail=0, timeout=0, tries_left=MAX_TRIES, timeout counter 0.
REQ-036 rst SHALL override every other input in the same cycle, including mid-CHECK and LOCKED.

Configuration
REQ-037 With macro PIN_TIMEOUT_EN defined: in GET_PIN, a counter increments each cycle without an accepted digit and clears on an accepted digit; on reaching TIMEOUT_CYCLES, timeout pulses for one cycle and the state goes IDLE.
REQ-038 Without PIN_TIMEOUT_EN: no counter is built, timeout is tied 0, and GET_PIN waits indefinitely.

Verification
REQ-039 card_insert acc 3, digits 3,4,5,6, found=1 pin_ok=1 -> pin_out=3456, auth_req one cycle after 4th digit, authenticated=1 next cycle.
REQ-040 Acc 1, three wrong PINs (found=1 pin_ok=0) -> fail x3, tries_left 2,1,0, locked=1; later card_insert ignored until rst.
REQ-041 Acc 12, found=0 -> fail pulse, return IDLE, tries_left stays 3.
REQ-042 Digits 1,11,2,3,4 -> 11 ignored, pin_out=1234; cancel with digit_valid in same cycle -> IDLE, pin unchanged.
REQ-043 PIN_TIMEOUT_EN, TIMEOUT_CYCLES=8, one digit then 8 idle cycles -> timeout pulse, IDLE; without macro -> remains GET_PIN.
REQ-044 rst asserted during CHECK -> all outputs at reset values next cycle, auth_req=0.

Source files
------------

// File: rtl/pin_entry_controller.sv
// PIN entry sequencer: latches a card account, gathers four decimal digits, requests a check and tracks lockout.
// Optional GET_PIN inactivity abandon is built only when PIN_TIMEOUT_EN is defined.
module pin_entry_controller #(
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_insert,
  input  logic [3:0]  acc_num_in,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        cancel,
  input  logic        auth_found,
  input  logic        auth_pin_ok,
  output logic [3:0]  acc_num_out,
  output logic [15:0] pin_out,
  output logic        auth_req,
  output logic        authenticated,
  output logic        locked,
  output logic        fail,
  output logic [1:0]  tries_left,
  output logic        timeout
);

  // state   | meaning
  // IDLE    | waiting for a card
  // GET_PIN | collecting keypad digits
  // CHECK   | auth_req high, authenticator result sampled at cycle end
  // AUTH_OK | session open until cancel
  // LOCKED  | card locked out, only rst leaves
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_PIN = 3'd1,
    CHECK   = 3'd2,
    AUTH_OK = 3'd3,
    LOCKED  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  acc_nxt;
  logic [15:0] pin_nxt;
  logic [15:0] pin_x10;
  logic [2:0]  count, count_nxt;
  logic [1:0]  tries_nxt;
  logic        fail_nxt;
  logic        digit_ok;
  logic        tmr_hit;

  assign digit_ok = digit_valid && (digit <= 4'd9);
  assign pin_x10  = (pin_out << 3) + (pin_out << 1);

`ifdef PIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmr, tmr_nxt;
  logic          timeout_q;

  // Abandon on the cycle the idle count would reach TIMEOUT_CYCLES.
  assign tmr_hit = (state == GET_PIN) && !cancel && !digit_ok &&
                   (tmr == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmr_nxt = '0;
    if ((state == GET_PIN) && !cancel && !digit_ok && !tmr_hit)
      tmr_nxt = tmr + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr       <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmr       <= tmr_nxt;
      timeout_q <= tmr_hit;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmr_hit            = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_num_out;
    pin_nxt   = pin_out;
    count_nxt = count;
    tries_nxt = tries_left;
    fail_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (card_insert) begin
          acc_nxt   = acc_num_in;
          pin_nxt   = '0;
          count_nxt = '0;
          tries_nxt = 2'(MAX_TRIES);
          state_nxt = GET_PIN;
        end
      end
      GET_PIN: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else if (digit_ok) begin
          pin_nxt   = pin_x10 + {12'd0, digit};
          count_nxt = count + 3'd1;
          if (count == 3'd3) state_nxt = CHECK;
        end else if (tmr_hit) begin
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else if (!auth_found) begin
          fail_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (auth_pin_ok) begin
          state_nxt = AUTH_OK;
        end else begin
          fail_nxt = 1'b1;
          if (tries_left != 2'd0) tries_nxt = tries_left - 2'd1;
          if (tries_left <= 2'd1) begin
            state_nxt = LOCKED;
          end else begin
            pin_nxt   = '0;
            count_nxt = '0;
            state_nxt = GET_PIN;
          end
        end
      end
      AUTH_OK: begin
        if (cancel) state_nxt = IDLE;
      end
      LOCKED: begin
        state_nxt = LOCKED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc_num_out <= '0;
      pin_out     <= '0;
      count       <= '0;
      tries_left  <= 2'(MAX_TRIES);
      fail        <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc_num_out <= acc_nxt;
      pin_out     <= pin_nxt;
      count       <= count_nxt;
      tries_left  <= tries_nxt;
      fail        <= fail_nxt;
    end
  end

  assign auth_req      = (state == CHECK);
  assign authenticated = (state == AUTH_OK);
  assign locked        = (state == LOCKED);

endmodule

// File: tb/tb_pin_entry_controller.sv
// Directed bench for pin_entry_controller: vector table plus reset-in-CHECK and inactivity sequences.
// Works in both builds; the inactivity expectations follow PIN_TIMEOUT_EN.
module tb_pin_entry_controller;

  logic        clk = 1'b0;
  logic        rst, card_insert, digit_valid, cancel, auth_found, auth_pin_ok;
  logic [3:0]  acc_num_in, digit;
  logic [3:0]  acc_num_out;
  logic [15:0] pin_out;
  logic        auth_req, authenticated, locked, fail, timeout;
  logic [1:0]  tries_left;

  int errors = 0;
  int checks = 0;

  pin_entry_controller #(.MAX_TRIES(3), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .card_insert(card_insert), .acc_num_in(acc_num_in),
    .digit_valid(digit_valid), .digit(digit), .cancel(cancel),
    .auth_found(auth_found), .auth_pin_ok(auth_pin_ok),
    .acc_num_out(acc_num_out), .pin_out(pin_out), .auth_req(auth_req),
    .authenticated(authenticated), .locked(locked), .fail(fail),
    .tries_left(tries_left), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, ci;
    logic [3:0]  acc;
    logic        dv;
    logic [3:0]  dig;
    logic        can, fnd, ok;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Expected outputs packed as {acc, pin, auth_req, authenticated, locked, fail, tries, timeout}.
  function automatic logic [26:0] pk(input logic [3:0] a, input logic [15:0] p, input logic rq,
                                     input logic au, input logic lk, input logic fl,
                                     input logic [1:0] tr, input logic to);
    return {a, p, rq, au, lk, fl, tr, to};
  endfunction

  function automatic vec_t mk(input string n, input logic r, input logic ci, input logic [3:0] acc,
                              input logic dv, input logic [3:0] dig, input logic can,
                              input logic fnd, input logic ok, input logic [26:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.ci = ci; v.acc = acc; v.dv = dv; v.dig = dig;
    v.can = can; v.fnd = fnd; v.ok = ok; v.exp = e;
    return v;
  endfunction

  function automatic logic [26:0] actual();
    return {acc_num_out, pin_out, auth_req, authenticated, locked, fail, tries_left, timeout};
  endfunction

  task automatic check(input string n, input logic [26:0] e);
    logic [26:0] a;
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got acc=%0d pin=%0d req=%b auth=%b lock=%b fail=%b tries=%0d to=%b, expected acc=%0d pin=%0d req=%b auth=%b lock=%b fail=%b tries=%0d to=%b",
               n, a[26:23], a[22:7], a[6], a[5], a[4], a[3], a[2:1], a[0],
               e[26:23], e[22:7], e[6], e[5], e[4], e[3], e[2:1], e[0]);
    end
  endtask

  task automatic drive(input logic r, input logic ci, input logic [3:0] acc, input logic dv,
                       input logic [3:0] dig, input logic can, input logic fnd, input logic ok);
    rst = r; card_insert = ci; acc_num_in = acc; digit_valid = dv; digit = dig;
    cancel = can; auth_found = fnd; auth_pin_ok = ok;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic key(input logic [3:0] d);
    drive(0, 0, 0, 1, d, 0, 0, 0);
    step();
  endtask

  initial begin
    logic [26:0] rv;
    logic        ten;
    rv = pk(0, 0, 0, 0, 0, 0, 3, 0);

    //                name        rst ci acc dv dig can f ok   expected after the edge
    vecs.push_back(mk("reset",     1, 0, 0,  0, 0,  0, 0, 0, rv));
    vecs.push_back(mk("ins3",      0, 1, 3,  0, 0,  0, 0, 0, pk(3, 0, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("d3",        0, 0, 0,  1, 3,  0, 0, 0, pk(3, 3, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("d4",        0, 0, 0,  1, 4,  0, 0, 0, pk(3, 34, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("d5",        0, 0, 0,  1, 5,  0, 0, 0, pk(3, 345, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("d6_req",    0, 0, 0,  1, 6,  0, 0, 0, pk(3, 3456, 1, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("chk_ok",    0, 0, 0,  1, 7,  0, 1, 1, pk(3, 3456, 0, 1, 0, 0, 3, 0)));
    vecs.push_back(mk("ins_ign",   0, 1, 5,  0, 0,  0, 0, 0, pk(3, 3456, 0, 1, 0, 0, 3, 0)));
    vecs.push_back(mk("auth_hold", 0, 0, 0,  1, 2,  0, 0, 0, pk(3, 3456, 0, 1, 0, 0, 3, 0)));
    vecs.push_back(mk("can_auth",  0, 0, 0,  0, 0,  1, 0, 0, pk(3, 3456, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("ins12",     0, 1, 12, 0, 0,  0, 0, 0, pk(12, 0, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("a12_d1",    0, 0, 0,  1, 1,  0, 0, 0, pk(12, 1, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("a12_d2",    0, 0, 0,  1, 2,  0, 0, 0, pk(12, 12, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("a12_d3",    0, 0, 0,  1, 3,  0, 0, 0, pk(12, 123, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("a12_d4",    0, 0, 0,  1, 4,  0, 0, 0, pk(12, 1234, 1, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("not_found", 0, 0, 0,  0, 0,  0, 0, 1, pk(12, 1234, 0, 0, 0, 1, 3, 0)));
    vecs.push_back(mk("fail_clr",  0, 0, 0,  0, 0,  0, 0, 0, pk(12, 1234, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("ins7",      0, 1, 7,  0, 0,  0, 0, 0, pk(7, 0, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("a7_d1",     0, 0, 0,  1, 1,  0, 0, 0, pk(7, 1, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("a7_d11",    0, 0, 0,  1, 11, 0, 0, 0, pk(7, 1, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("a7_d10",    0, 0, 0,  1, 10, 0, 0, 0, pk(7, 1, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("a7_d2",     0, 0, 0,  1, 2,  0, 0, 0, pk(7, 12, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("a7_d3",     0, 0, 0,  1, 3,  0, 0, 0, pk(7, 123, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("a7_d4",     0, 0, 0,  1, 4,  0, 0, 0, pk(7, 1234, 1, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("can_chk",   0, 0, 0,  1, 5,  1, 1, 1, pk(7, 1234, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("ins2",      0, 1, 2,  0, 0,  0, 0, 0, pk(2, 0, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("a2_d9",     0, 0, 0,  1, 9,  0, 0, 0, pk(2, 9, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("can_dig",   0, 0, 0,  1, 8,  1, 0, 0, pk(2, 9, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("idle_dig",  0, 0, 0,  1, 5,  0, 0, 0, pk(2, 9, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("ins1",      0, 1, 1,  0, 0,  0, 0, 0, pk(1, 0, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("t1_d9",     0, 0, 0,  1, 9,  0, 0, 0, pk(1, 9, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("t1_d8",     0, 0, 0,  1, 8,  0, 0, 0, pk(1, 98, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("t1_d7",     0, 0, 0,  1, 7,  0, 0, 0, pk(1, 987, 0, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("t1_d6",     0, 0, 0,  1, 6,  0, 0, 0, pk(1, 9876, 1, 0, 0, 0, 3, 0)));
    vecs.push_back(mk("wrong1",    0, 0, 0,  0, 0,  0, 1, 0, pk(1, 0, 0, 0, 0, 1, 2, 0)));
    vecs.push_back(mk("t2_d1a",    0, 0, 0,  1, 1,  0, 0, 0, pk(1, 1, 0, 0, 0, 0, 2, 0)));
    vecs.push_back(mk("t2_d1b",    0, 0, 0,  1, 1,  0, 0, 0, pk(1, 11, 0, 0, 0, 0, 2, 0)));
    vecs.push_back(mk("t2_d1c",    0, 0, 0,  1, 1,  0, 0, 0, pk(1, 111, 0, 0, 0, 0, 2, 0)));
    vecs.push_back(mk("t2_d1d",    0, 0, 0,  1, 1,  0, 0, 0, pk(1, 1111, 1, 0, 0, 0, 2, 0)));
    vecs.push_back(mk("wrong2",    0, 0, 0,  0, 0,  0, 1, 0, pk(1, 0, 0, 0, 0, 1, 1, 0)));
    vecs.push_back(mk("t3_d2a",    0, 0, 0,  1, 2,  0, 0, 0, pk(1, 2, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mk("t3_d2b",    0, 0, 0,  1, 2,  0, 0, 0, pk(1, 22, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mk("t3_d2c",    0, 0, 0,  1, 2,  0, 0, 0, pk(1, 222, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mk("t3_d2d",    0, 0, 0,  1, 2,  0, 0, 0, pk(1, 2222, 1, 0, 0, 0, 1, 0)));
    vecs.push_back(mk("wrong3",    0, 0, 0,  0, 0,  0, 1, 0, pk(1, 2222, 0, 0, 1, 1, 0, 0)));
    vecs.push_back(mk("lk_ins",    0, 1, 4,  1, 5,  1, 0, 0, pk(1, 2222, 0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk("lk_hold",   0, 0, 0,  0, 0,  0, 1, 1, pk(1, 2222, 0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk("lk_rst",    1, 1, 9,  1, 3,  0, 1, 1, rv));
    vecs.push_back(mk("ins6",      0, 1, 6,  0, 0,  0, 0, 0, pk(6, 0, 0, 0, 0, 0, 3, 0)));

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ci, vecs[i].acc, vecs[i].dv, vecs[i].dig,
            vecs[i].can, vecs[i].fnd, vecs[i].ok);
      step();
      check(vecs[i].name, vecs[i].exp);
    end

    // Reset while CHECK is active, with a passing result and a card insert also present.
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    step();
    drive(0, 1, 5, 0, 0, 0, 0, 0);
    step();
    key(1); key(2); key(3); key(4);
    check("rst_chk_pre", pk(5, 1234, 1, 0, 0, 0, 3, 0));
    drive(1, 1, 8, 1, 7, 0, 1, 1);
    step();
    check("rst_in_check", rv);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    step();
    check("rst_chk_post", rv);

    // Inactivity: one digit, then eight idle cycles in GET_PIN.
`ifdef PIN_TIMEOUT_EN
    ten = 1'b1;
`else
    ten = 1'b0;
`endif
    drive(0, 1, 9, 0, 0, 0, 0, 0);
    step();
    key(5);
    idle_in();
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) check("to_idle7", pk(9, 5, 0, 0, 0, 0, 3, 0));
    end
    check("to_idle8", pk(9, 5, 0, 0, 0, 0, 3, ten));
    step();
    check("to_pulse_end", pk(9, 5, 0, 0, 0, 0, 3, 0));
    key(6); key(7); key(8);
    if (ten) check("to_after", pk(9, 5, 0, 0, 0, 0, 3, 0));
    else     check("to_after", pk(9, 5678, 1, 0, 0, 0, 3, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
